// File: rtl/branch_pkg.sv
// rtl/branch_pkg.sv - condition codes and FSM encoding shared by the branch resolver
package branch_pkg;

  localparam logic [2:0] COND_EQ = 3'd0;
  localparam logic [2:0] COND_NE = 3'd1;
  localparam logic [2:0] COND_LT = 3'd2;
  localparam logic [2:0] COND_GE = 3'd3;
  localparam logic [2:0] COND_LE = 3'd4;
  localparam logic [2:0] COND_GT = 3'd5;
  localparam logic [2:0] COND_AL = 3'd6;
  localparam logic [2:0] COND_NV = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - Z/N decode of the comparator difference and condition evaluation
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] comp,
  input  logic [2:0]       cond,
  output logic             taken
);

  logic z;
  logic n;

  // The difference is treated as signed with no overflow correction: the sign bit is LT.
  assign z = (comp == '0);
  assign n = comp[WIDTH-1];

  always_comb begin
    taken = 1'b0;
    case (cond)
      COND_EQ: taken = z;
      COND_NE: taken = !z;
      COND_LT: taken = n;
      COND_GE: taken = !n;
      COND_LE: taken = z | n;
      COND_GT: taken = !z & !n;
      COND_AL: taken = 1'b1;
      COND_NV: taken = 1'b0;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// rtl/branch_resolver.sv - branch request FSM driving the comparator; optional counters under BRANCH_RESOLVER_STATS_EN
module branch_resolver
  import branch_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_req,
  input  logic [2:0]       cond,
  input  logic [WIDTH-1:0] br_target,
  input  logic [WIDTH-1:0] pc_next,
  input  logic [WIDTH-1:0] comp,
  output logic             compen,
  output logic             br_ack,
  output logic             br_taken,
  output logic [WIDTH-1:0] pc_out
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [15:0]      br_count,
  output logic [15:0]      taken_count
`endif
);

  state_t           state_q;
  state_t           state_d;
  logic [2:0]       cond_q;
  logic [WIDTH-1:0] target_q;
  logic [WIDTH-1:0] pcn_q;
  logic             taken;

  branch_cond_eval #(.WIDTH(WIDTH)) u_cond_eval (
    .comp  (comp),
    .cond  (cond_q),
    .taken (taken)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (br_req) state_d = CMP;
      CMP:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // AL/NV leave the comparator untouched so its stored value survives.
  always_comb begin
    compen = 1'b0;
    br_ack = 1'b0;
    if (state_q == CMP)  compen = (cond_q <= COND_GT);
    if (state_q == DONE) br_ack = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_q   <= '0;
      target_q <= '0;
      pcn_q    <= '0;
      br_taken <= 1'b0;
      pc_out   <= '0;
    end else begin
      if (state_q == IDLE && br_req) begin
        cond_q   <= cond;
        target_q <= br_target;
        pcn_q    <= pc_next;
      end
      if (state_q == CMP) begin
        br_taken <= taken;
        pc_out   <= taken ? target_q : pcn_q;
      end
    end
  end

`ifdef BRANCH_RESOLVER_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count    <= '0;
      taken_count <= '0;
    end else if (state_q == CMP) begin
      if (br_count != 16'hFFFF) br_count <= br_count + 16'd1;
      if (taken && taken_count != 16'hFFFF) taken_count <= taken_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// tb/tb_branch_resolver.sv - directed self-checking bench for branch_resolver
module tb_branch_resolver;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             br_req = 1'b0;
  logic [2:0]       cond = 3'd0;
  logic [WIDTH-1:0] br_target = '0;
  logic [WIDTH-1:0] pc_next = '0;
  logic [WIDTH-1:0] comp = '0;
  logic             compen;
  logic             br_ack;
  logic             br_taken;
  logic [WIDTH-1:0] pc_out;
`ifdef BRANCH_RESOLVER_STATS_EN
  logic [15:0]      br_count;
  logic [15:0]      taken_count;
`endif

  logic [WIDTH-1:0] i1 = '0;
  logic [WIDTH-1:0] i2 = '0;
  int checks = 0;
  int failures = 0;

  branch_resolver #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .br_req    (br_req),
    .cond      (cond),
    .br_target (br_target),
    .pc_next   (pc_next),
    .comp      (comp),
    .compen    (compen),
    .br_ack    (br_ack),
    .br_taken  (br_taken),
    .pc_out    (pc_out)
`ifdef BRANCH_RESOLVER_STATS_EN
    ,
    .br_count    (br_count),
    .taken_count (taken_count)
`endif
  );

  always #5 clk = ~clk;

  // Comparator model: latches the difference on the negedge while enabled.
  always @(negedge clk) if (compen) comp <= i1 - i2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, scrambles the inputs after acceptance, waits for the ack.
  task automatic run_branch(input logic [2:0] c, input logic [WIDTH-1:0] tgt,
                            input logic [WIDTH-1:0] pcn,
                            output int cycles, output logic saw_compen);
    br_req = 1'b1; cond = c; br_target = tgt; pc_next = pcn;
    cycles = 0; saw_compen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      cycles++;
      if (compen) saw_compen = 1'b1;
      if (cycles == 1) begin
        cond = ~c; br_target = 32'hDEAD_0000; pc_next = 32'hBEEF_0000;
      end
      if (br_ack) break;
    end
    br_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++;
    if ({compen, br_ack, br_taken} !== 3'b000 || pc_out !== '0) begin
      failures++;
      $display("FAIL reset_outputs: compen/ack/taken=%b pc_out=%h required 000 / 0", {compen, br_ack, br_taken}, pc_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_eq();
    int cyc; logic sc;
    i1 = 5; i2 = 5;
    run_branch(3'd0, 32'h100, 32'h44, cyc, sc);
    checks++;
    if (cyc !== 2) begin failures++; $display("FAIL eq_latency: ack after %0d cycles required 2", cyc); end
    checks++;
    if (sc !== 1'b1) begin failures++; $display("FAIL eq_compen: saw %b required 1", sc); end
    checks++;
    if (br_taken !== 1'b1 || pc_out !== 32'h100) begin
      failures++; $display("FAIL eq_result: taken=%b pc_out=%h required 1 / 00000100", br_taken, pc_out);
    end
  endtask

  task automatic test_reset_mid_cmp();
    br_req = 1'b1; cond = 3'd0; br_target = 32'h55; pc_next = 32'h66;
    tick();
    checks++;
    if (compen !== 1'b1) begin failures++; $display("FAIL midcmp_compen_before: compen=%b required 1", compen); end
    rst = 1'b1;
    #1;
    checks++;
    if (compen !== 1'b0 || br_ack !== 1'b0 || pc_out !== '0 || br_taken !== 1'b0) begin
      failures++;
      $display("FAIL midcmp_reset: compen=%b ack=%b taken=%b pc_out=%h required 0 0 0 0", compen, br_ack, br_taken, pc_out);
    end
    br_req = 1'b0;
    tick();
    rst = 1'b0;
    begin
      logic seen_ack = 1'b0;
      for (int k = 0; k < 4; k++) begin tick(); if (br_ack || compen) seen_ack = 1'b1; end
      checks++;
      if (seen_ack !== 1'b0) begin failures++; $display("FAIL midcmp_no_ack: activity=%b required 0", seen_ack); end
    end
  endtask

  task automatic test_lt_gt();
    int cyc; logic sc;
    i1 = 3; i2 = 7;
    run_branch(3'd2, 32'h2000, 32'h1004, cyc, sc);
    checks++;
    if (br_taken !== 1'b1 || pc_out !== 32'h2000) begin
      failures++; $display("FAIL lt_taken: taken=%b pc_out=%h required 1 / 00002000", br_taken, pc_out);
    end
    run_branch(3'd5, 32'h3000, 32'h1008, cyc, sc);
    checks++;
    if (br_taken !== 1'b0 || pc_out !== 32'h1008) begin
      failures++; $display("FAIL gt_not_taken: taken=%b pc_out=%h required 0 / 00001008", br_taken, pc_out);
    end
    run_branch(3'd3, 32'h3100, 32'h100C, cyc, sc);
    checks++;
    if (br_taken !== 1'b0 || pc_out !== 32'h100C) begin
      failures++; $display("FAIL ge_not_taken: taken=%b pc_out=%h required 0 / 0000100c", br_taken, pc_out);
    end
  endtask

  task automatic test_le_gt_zero();
    int cyc; logic sc;
    i1 = 9; i2 = 9;
    run_branch(3'd4, 32'h4000, 32'h1010, cyc, sc);
    checks++;
    if (br_taken !== 1'b1 || pc_out !== 32'h4000) begin
      failures++; $display("FAIL le_zero: taken=%b pc_out=%h required 1 / 00004000", br_taken, pc_out);
    end
    run_branch(3'd5, 32'h5000, 32'h1014, cyc, sc);
    checks++;
    if (br_taken !== 1'b0 || pc_out !== 32'h1014) begin
      failures++; $display("FAIL gt_zero: taken=%b pc_out=%h required 0 / 00001014", br_taken, pc_out);
    end
    run_branch(3'd1, 32'h5100, 32'h1018, cyc, sc);
    checks++;
    if (br_taken !== 1'b0 || pc_out !== 32'h1018) begin
      failures++; $display("FAIL ne_zero: taken=%b pc_out=%h required 0 / 00001018", br_taken, pc_out);
    end
  endtask

  task automatic test_al_nv();
    int cyc; logic sc;
    i1 = 1; i2 = 2;
    run_branch(3'd6, 32'h6000, 32'h1020, cyc, sc);
    checks++;
    if (cyc !== 2 || sc !== 1'b0) begin
      failures++; $display("FAIL al_timing: cycles=%0d compen_seen=%b required 2 / 0", cyc, sc);
    end
    checks++;
    if (br_taken !== 1'b1 || pc_out !== 32'h6000) begin
      failures++; $display("FAIL al_result: taken=%b pc_out=%h required 1 / 00006000", br_taken, pc_out);
    end
    run_branch(3'd7, 32'h7000, 32'h1024, cyc, sc);
    checks++;
    if (cyc !== 2 || sc !== 1'b0) begin
      failures++; $display("FAIL nv_timing: cycles=%0d compen_seen=%b required 2 / 0", cyc, sc);
    end
    checks++;
    if (br_taken !== 1'b0 || pc_out !== 32'h1024) begin
      failures++; $display("FAIL nv_result: taken=%b pc_out=%h required 0 / 00001024", br_taken, pc_out);
    end
    checks++;
    if (comp !== 32'h0) begin failures++; $display("FAIL al_nv_comp_kept: comp=%h required 00000000", comp); end
  endtask

  task automatic test_back_to_back();
    logic [2:0]       cv [3] = '{3'd0, 3'd1, 3'd6};
    logic [WIDTH-1:0] tv [3] = '{32'h200, 32'h300, 32'h400};
    logic [WIDTH-1:0] pv [3] = '{32'h204, 32'h304, 32'h404};
    logic             ev [3] = '{1'b1, 1'b0, 1'b1};
    int ack_t [3];
    int n = 0;
    int t = 0;
`ifdef BRANCH_RESOLVER_STATS_EN
    logic [15:0] bc0 = br_count;
    logic [15:0] tc0 = taken_count;
`endif
    i1 = 5; i2 = 5;
    br_req = 1'b1; cond = cv[0]; br_target = tv[0]; pc_next = pv[0];
    while (n < 3 && t < 20) begin
      tick();
      t++;
      if (br_ack) begin
        ack_t[n] = t;
        checks++;
        if (br_taken !== ev[n] || pc_out !== (ev[n] ? tv[n] : pv[n])) begin
          failures++;
          $display("FAIL b2b_result%0d: taken=%b pc_out=%h required %b / %h", n, br_taken, pc_out, ev[n], ev[n] ? tv[n] : pv[n]);
        end
        n++;
        if (n < 3) begin cond = cv[n]; br_target = tv[n]; pc_next = pv[n]; end
        else br_req = 1'b0;
      end else if (compen || dut.state_q == 2'd1) begin
        cond = ~cond; br_target = 32'hBAD0_0000; pc_next = 32'hBAD1_0000;
      end
    end
    br_req = 1'b0;
    checks++;
    if (n !== 3) begin
      failures++; $display("FAIL b2b_ack_count: acks=%0d required 3", n);
    end else begin
      checks++;
      if (ack_t[1] - ack_t[0] !== 3 || ack_t[2] - ack_t[1] !== 3) begin
        failures++; $display("FAIL b2b_spacing: gaps=%0d,%0d required 3,3", ack_t[1] - ack_t[0], ack_t[2] - ack_t[1]);
      end
    end
    tick();
`ifdef BRANCH_RESOLVER_STATS_EN
    checks++;
    if (br_count - bc0 !== 16'd3 || taken_count - tc0 !== 16'd2) begin
      failures++;
      $display("FAIL b2b_stats: br_delta=%0d taken_delta=%0d required 3 / 2", br_count - bc0, taken_count - tc0);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_eq();
    test_reset_mid_cmp();
    test_lt_gt();
    test_le_gt_zero();
    test_al_nv();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
